// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: pixel tick in, raster coordinates, syncs and strobes out.
interface vga_timing_gen_if #(
  parameter int CW  = 11,
  parameter int FCW = 8
) ();

  logic           pix_en;
  logic [CW-1:0]  x;
  logic [CW-1:0]  y;
  logic           hsync;
  logic           vsync;
  logic           active;
  logic           line_start;
  logic           frame_start;
  logic [FCW-1:0] frame_cnt;

  // Generator side: consumes the pixel tick, produces the timing.
  modport master (
    input  pix_en,
    output x, y, hsync, vsync, active, line_start, frame_start, frame_cnt
  );

  // Consumer side: supplies the pixel tick, receives the timing.
  modport slave (
    output pix_en,
    input  x, y, hsync, vsync, active, line_start, frame_start, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters advanced by a pixel
// tick, with all visible outputs registered one clock behind the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int H_POL    = 1,
  parameter int V_POL    = 1,
  parameter int CW       = 11,
  parameter int FCW      = 8
) (
  input  logic                clk,
  input  logic                rst,
  vga_timing_gen_if.master    vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;
  localparam longint CNT_RANGE = longint'(1) << CW;

  // Reject parameter sets the counters cannot represent or that make no sense.
  if (CNT_RANGE < longint'(MAX_TOTAL)) begin : g_bad_cw
    $error("vga_timing_gen: CW too narrow for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0) begin : g_bad_hpar
    $error("vga_timing_gen: horizontal porch/sync must be nonzero");
  end
  if (V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_vpar
    $error("vga_timing_gen: vertical porch/sync must be nonzero");
  end
  if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_bad_active
    $error("vga_timing_gen: active area must be nonzero");
  end

  // Boundaries as counter-width constants so compares stay width-matched.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  logic [CW-1:0]  h_cnt_reg, h_cnt_next;
  logic [CW-1:0]  v_cnt_reg, v_cnt_next;
  logic [FCW-1:0] f_cnt_reg, f_cnt_next;

  logic [CW-1:0]  x_reg, y_reg;
  logic           hsync_reg, hsync_next;
  logic           vsync_reg, vsync_next;
  logic           active_reg, active_next;
  logic           line_start_reg, line_start_next;
  logic           frame_start_reg, frame_start_next;
  logic [FCW-1:0] frame_cnt_reg;

  logic h_last, v_last, h_zero, v_zero;

  assign h_last = (h_cnt_reg == H_LAST);
  assign v_last = (v_cnt_reg == V_LAST);
  assign h_zero = (h_cnt_reg == '0);
  assign v_zero = (v_cnt_reg == '0);

  // Counter advance: only on a pixel tick; line wrap carries into v, frame wrap into f.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    f_cnt_next = f_cnt_reg;
    if (vif.pix_en) begin
      if (h_last) begin
        h_cnt_next = '0;
        if (v_last) begin
          v_cnt_next = '0;
          f_cnt_next = f_cnt_reg + FCW'(1);
        end else begin
          v_cnt_next = v_cnt_reg + CW'(1);
        end
      end else begin
        h_cnt_next = h_cnt_reg + CW'(1);
      end
    end
  end

  // Output decode of the current (pre-edge) counters; held counters give held outputs.
  always_comb begin
    hsync_next       = ~HS_ON;
    vsync_next       = ~VS_ON;
    active_next      = 1'b0;
    line_start_next  = 1'b0;
    frame_start_next = 1'b0;
    if (h_cnt_reg >= HS_START && h_cnt_reg < HS_END) begin
      hsync_next = HS_ON;
    end
    if (v_cnt_reg >= VS_START && v_cnt_reg < VS_END) begin
      vsync_next = VS_ON;
    end
    active_next      = (h_cnt_reg < H_VIS) && (v_cnt_reg < V_VIS);
    line_start_next  = vif.pix_en && h_zero;
    frame_start_next = vif.pix_en && h_zero && v_zero;
  end

  // Counter state; reset wins over the pixel tick and abandons the current frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
      f_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
      f_cnt_reg <= f_cnt_next;
    end
  end

  // Output registers: one clock behind the counters, idle levels under reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg           <= '0;
      y_reg           <= '0;
      hsync_reg       <= ~HS_ON;
      vsync_reg       <= ~VS_ON;
      active_reg      <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      x_reg           <= h_cnt_reg;
      y_reg           <= v_cnt_reg;
      hsync_reg       <= hsync_next;
      vsync_reg       <= vsync_next;
      active_reg      <= active_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_cnt_reg   <= f_cnt_reg;
    end
  end

  assign vif.x           = x_reg;
  assign vif.y           = y_reg;
  assign vif.hsync       = hsync_reg;
  assign vif.vsync       = vsync_reg;
  assign vif.active      = active_reg;
  assign vif.line_start  = line_start_reg;
  assign vif.frame_start = frame_start_reg;
  assign vif.frame_cnt   = frame_cnt_reg;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-002 Parameter H_FP, default 40: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 128: horizontal sync width, in pixels.
REQ-004 Parameter H_BP, default 88: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 600: visible lines per frame.
REQ-006 Parameter V_FP, default 1: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 4: vertical sync width, in lines.
REQ-008 Parameter V_BP, default 23: vertical back porch, in lines.
REQ-009 Parameter H_POL, default 1: hsync asserted level.
REQ-010 Parameter V_POL, default 1: vsync asserted level.
REQ-011 Parameter CW, default 11: width of the coordinate counters.
REQ-012 Parameter FCW, default 8: width of the frame counter.
REQ-013 clk  in  1  single clock; all logic on rising edge.
REQ-014 rst  in  1  reset; synchronous, active-high.
REQ-015 pix_en  in  1  pixel tick; counters advance only when high.
REQ-016 x  out  CW  registered horizontal count, 0..H_TOTAL-1.
REQ-017 y  out  CW  registered vertical count, 0..V_TOTAL-1.
REQ-018 hsync  out  1  horizontal sync at polarity H_POL.
REQ-019 vsync  out  1  vertical sync at polarity V_POL.
REQ-020 active  out  1  high while (x,y) is inside the visible area.
REQ-021 line_start  out  1  one-clk strobe on the pixel tick where h_cnt=0.
REQ-022 frame_start  out  1  one-clk strobe on the pixel tick where h_cnt=0 and v_cnt=0.
REQ-023 frame_cnt  out  FCW  completed-frame counter; wraps modulo 2^FCW.

Function
REQ-024 Derived totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
REQ-025 Elaboration SHALL fail when any of the following holds: 2^CW < max(H_TOTAL,V_TOTAL); any porch or sync parameter is 0; H_ACTIVE is 0; V_ACTIVE is 0.
REQ-026 Internal counters h_cnt and v_cnt SHALL hold their values on any clk where pix_en=0.
REQ-027 On pix_en=1, h_cnt SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and v_cnt SHALL increment.
REQ-028 When v_cnt=V_TOTAL-1 and h_cnt wraps, v_cnt SHALL wrap to 0 and frame_cnt SHALL increment, wrapping modulo 2^FCW.
REQ-029 All outputs SHALL be registered decodes of the pre-edge h_cnt/v_cnt, so outputs lag the counters by exactly 1 clk.
REQ-030 x and y SHALL equal h_cnt and v_cnt respectively, delayed 1 clk.
REQ-031 hsync SHALL be at level H_POL while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and ~H_POL otherwise.
REQ-032 vsync SHALL be at level V_POL while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, for whole lines, and ~V_POL otherwise.
REQ-033 active SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-034 line_start SHALL equal pix_en AND (h_cnt=0), registered; frame_start SHALL additionally require v_cnt=0; neither strobe SHALL stretch while pix_en=0.
REQ-035 hsync, vsync, active, x and y SHALL hold steady while pix_en=0.
REQ-036 The vsync edges and the frame_cnt increment SHALL coincide with the h_cnt wrap, never mid-line.

Reset
REQ-037 On rst=1 at a clk edge, h_cnt, v_cnt, x, y and frame_cnt SHALL all be 0.
REQ-038 On rst=1 at a clk edge, active, line_start and frame_start SHALL be 0, hsync SHALL be ~H_POL and vsync SHALL be ~V_POL.
REQ-039 rst SHALL take priority over pix_en.
REQ-040 A reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start at (0,0) with no partial sync pulse.
REQ-041 On the first clk after rst falls, outputs SHALL show the (0,0) decode: active=1; frame_start=1 if pix_en was 1 on that clk.

Verification
Directed tests use small parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), H_POL=0, V_POL=1, CW=4, FCW=2.
REQ-042 Scenario, continuous timing: rst for 2 clks, then pix_en=1 continuously -> active high on x=0..3, hsync=0 on x=5..6, vsync=1 on all of y=4, frame_start every 48 clks.
REQ-043 Scenario, pixel-tick gating: pix_en toggling 1/0 -> all outputs advance every 2 clks, line_start width stays 1 clk, and line_start occurs every 16 clks.
REQ-044 Scenario, frame counter wrap: run 5 frames -> frame_cnt sequence 1,2,3,0,1, each increment on the clk after x=7,y=5.
REQ-045 Scenario, reset mid-operation: assert rst at x=5,y=4 (hsync and vsync both asserted) -> next clk hsync=1, vsync=0, x=y=0, frame_cnt=0.
REQ-046 Scenario, reset priority: rst=1 and pix_en=1 held for 3 clks -> counters stay 0 and no strobe is produced.
REQ-047 Scenario, default parameters: full frame run -> exactly 1056x628 pixel ticks per frame_start and 480000 active ticks.
